// File: rtl/disparity_packetizer.sv
// Frames a decoded disparity byte stream into sync/tag/count packets for a USB FIFO.
// Ports: clock/reset_n, valid_in/data_in source bytes, ready_in/valid_out/data_out sink handshake,
//        overflow (sticky drop flag), frame_count (completed frames, mod 256).
module disparity_packetizer #(
    parameter int LINE_PIXELS = 640,
    parameter int LINES       = 480,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    input  logic       ready_in,
    output logic       valid_out,
    output logic [7:0] data_out,
    output logic       overflow,
    output logic [7:0] frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PIX  = PW'(LINE_PIXELS - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

    typedef enum logic [2:0] {
        IDLE, F_SYNC, F_TAG, F_CNT, L_SYNC, L_TAG, L_IDX, PAYLOAD
    } state_t;

    state_t state, state_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_index;

    logic       empty, full, can_load, load, pop, push, line_end, last_line;
    logic [7:0] load_byte, din;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    // Output register may take a new byte when empty or being drained this cycle.
    assign can_load  = !valid_out || ready_in;
    assign last_line = (line_index == LAST_LINE);
    // 0xFF is reserved as the sync marker, so payload can never carry it.
    assign din       = (data_in == 8'hFF) ? 8'hFE : data_in;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push      = valid_in && (!full || pop);

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        load_byte = 8'h00;
        pop       = 1'b0;
        line_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) state_n = F_SYNC;
            end
            F_SYNC: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_byte = 8'hFF;
                    state_n   = F_TAG;
                end
            end
            F_TAG: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_byte = 8'h00;
                    state_n   = F_CNT;
                end
            end
            F_CNT: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_byte = frame_count;
                    state_n   = L_SYNC;
                end
            end
            L_SYNC: begin
                if (can_load && !empty) begin
                    load      = 1'b1;
                    load_byte = 8'hFF;
                    state_n   = L_TAG;
                end
            end
            L_TAG: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_byte = 8'h01;
                    state_n   = L_IDX;
                end
            end
            L_IDX: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_byte = 8'(line_index);
                    state_n   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (can_load && !empty) begin
                    load      = 1'b1;
                    pop       = 1'b1;
                    load_byte = mem[rd_ptr];
                    if (pix_cnt == LAST_PIX) begin
                        line_end = 1'b1;
                        state_n  = last_line ? IDLE : L_SYNC;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_out <= 1'b0;
            data_out  <= 8'h00;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= load_byte;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            if (valid_in && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt     <= '0;
            line_index  <= '0;
            frame_count <= 8'h00;
        end else if (pop) begin
            if (line_end) begin
                pix_cnt <= '0;
                if (last_line) begin
                    line_index  <= '0;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    line_index <= line_index + LW'(1);
                end
            end else begin
                pix_cnt <= pix_cnt + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_disparity_packetizer.sv
// Directed bench for disparity_packetizer with LINE_PIXELS=4, LINES=2.
// Transfers are captured on the falling edge and compared with hand-built packets.
module tb_disparity_packetizer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready_in = 1'b0;
    logic       valid_out;
    logic [7:0] data_out;
    logic       overflow;
    logic [7:0] frame_count;

    disparity_packetizer #(
        .LINE_PIXELS(4),
        .LINES      (2),
        .FIFO_DEPTH (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .overflow   (overflow),
        .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    int checks = 0;
    int fails = 0;

    // valid/ready are stable from here to the next rising edge.
    always @(negedge clock)
        if (reset_n && valid_out && ready_in) q.push_back(data_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        valid_in = 1'b1;
        data_in  = b;
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_q(input string tag, input int n);
        int k = 0;
        while (q.size() < n && k < 400) begin
            step();
            k++;
        end
        chk(tag, 32'(q.size() >= n), 32'd1);
    endtask

    function automatic void add_frame(input logic [7:0] fc, input logic [7:0] base);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(fc);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 8'(i));
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        for (int i = 4; i < 8; i++) exp_q.push_back(base + 8'(i));
    endfunction

    task automatic cmp_q(input string tag);
        chk({tag, "_len"}, 32'(q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? 32'(q[i]) : 32'hDEAD, 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        q.delete();
        exp_q.delete();
    endtask

    task automatic run_frame();
        for (int i = 0; i < 8; i++) push(8'(i));
        step(12);
    endtask

    initial begin
        logic stable;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        step(2);
        reset_n = 1'b1;
        step();

        // Basic framing with continuous input
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        wait_q("t1_wait", 17);
        step(5);
        add_frame(8'h00, 8'h10);
        cmp_q("t1");
        chk("t1_fc", 32'(frame_count), 32'd1);
        chk("t1_idle", 32'(valid_out), 32'd0);

        // 0xFF clamps to 0xFE in payload
        q.delete();
        exp_q = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'h01, 8'h00, 8'hFE, 8'h20, 8'h21,
                  8'h22, 8'hFF, 8'h01, 8'h01, 8'h23, 8'h24, 8'h25, 8'hFE};
        push(8'hFF);
        for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
        push(8'hFE);
        wait_q("t2_wait", 17);
        step(5);
        cmp_q("t2");
        chk("t2_fc", 32'(frame_count), 32'd2);

        // Backpressure: overflow on 17th byte, output held
        q.delete();
        exp_q.delete();
        ready_in = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(8'h30 + 8'(i));
            if (i >= 2) stable &= (valid_out === 1'b1) && (data_out === 8'hFF);
            if (i == 15) chk("t3_ovf_16", 32'(overflow), 32'd0);
            if (i == 16) chk("t3_ovf_17", 32'(overflow), 32'd1);
        end
        chk("t3_stable", 32'(stable), 32'd1);
        chk("t3_no_xfer", 32'(q.size()), 32'd0);
        ready_in = 1'b1;
        wait_q("t3_wait", 34);
        step(10);
        add_frame(8'h02, 8'h30);
        add_frame(8'h03, 8'h38);
        cmp_q("t3");
        chk("t3_fc", 32'(frame_count), 32'd4);
        chk("t3_sticky", 32'(overflow), 32'd1);

        // Push into a full FIFO while popping in PAYLOAD
        do_reset();
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        chk("t4_fc_clr", 32'(frame_count), 32'd0);
        ready_in = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h50 + 8'(i));
        chk("t4_full_ovf", 32'(overflow), 32'd0);
        ready_in = 1'b1;
        step(5);
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        chk("t4_ovf", 32'(overflow), 32'd0);
        step(40);
        add_frame(8'h00, 8'h50);
        add_frame(8'h01, 8'h58);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + 8'(i));
        cmp_q("t4");
        chk("t4_fc", 32'(frame_count), 32'd2);

        // Registered latency, then async reset mid-payload
        push(8'h70);
        step(8);
        ready_in = 1'b0;
        push(8'h71);
        step();
        chk("t5_lat_v", 32'(valid_out), 32'd1);
        chk("t5_lat_d", 32'(data_out), 32'h71);
        #3 reset_n = 1'b0;
        #1;
        chk("t5_async_v", 32'(valid_out), 32'd0);
        chk("t5_async_d", 32'(data_out), 32'h00);
        chk("t5_async_fc", 32'(frame_count), 32'd0);
        chk("t5_async_ovf", 32'(overflow), 32'd0);
        step();
        reset_n = 1'b1;
        q.delete();
        exp_q.delete();
        ready_in = 1'b1;
        step(5);
        chk("t5_empty", 32'(q.size()), 32'd0);
        push(8'h80);
        step(20);
        exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h80};
        cmp_q("t5");

        // frame_count wrap over 256 frames
        do_reset();
        for (int f = 0; f < 255; f++) run_frame();
        chk("t6_fc255", 32'(frame_count), 32'd255);
        chk("t6_len", 32'(q.size()), 32'(255 * 17));
        run_frame();
        chk("t6_wrap", 32'(frame_count), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        q.delete();
        push(8'h01);
        step(20);
        exp_q = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h01};
        cmp_q("t6");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/disparity_packetizer.md
DISPARITY_PACKETIZER -- requirements
Module: disparity_packetizer

Interface
REQ-001 Parameter LINE_PIXELS, default 640: payload bytes per line.
REQ-002 Parameter LINES, default 480: lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16: internal byte FIFO entries; power of two, at least 4.
REQ-004 Port clock, input, 1: single 200 MHz pipeline clock; all state on its rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port valid_in, input, 1: data_in carries one decoded disparity byte this cycle; no backpressure to the source.
REQ-007 Port data_in, input, 8: decoded disparity byte.
REQ-008 Port ready_in, input, 1: USB-side FIFO accepts a byte this cycle.
REQ-009 Port valid_out, output, 1: data_out holds a byte for the USB-side FIFO.
REQ-010 Port data_out, output, 8: framed output byte stream.
REQ-011 Port overflow, output, 1: sticky flag; an input byte was dropped.
REQ-012 Port frame_count, output, 8: number of completed frames, modulo 256.

Function
REQ-013 The block SHALL accept a byte when valid_in=1, clamp the value 0xFF to 0xFE, and write the result into the FIFO.
REQ-014 When the FIFO is full and no pop occurs in the same cycle, the input byte SHALL be dropped and overflow SHALL be set to 1.
REQ-015 When the FIFO is full and a pop occurs in the same cycle, the push SHALL succeed.
REQ-016 A transfer SHALL occur only when valid_out=1 and ready_in=1.
REQ-017 While valid_out=1 and ready_in=0, data_out and valid_out SHALL hold stable.
REQ-018 States SHALL be IDLE, F_SYNC, F_TAG, F_CNT, L_SYNC, L_TAG, L_IDX and PAYLOAD.
REQ-019 IDLE: valid_out=0; move to F_SYNC when the FIFO is non-empty.
REQ-020 F_SYNC, F_TAG and F_CNT SHALL present 0xFF, 0x00 and frame_count in turn, each advancing on transfer, with F_CNT advancing to L_SYNC.
REQ-021 L_SYNC, L_TAG and L_IDX SHALL present 0xFF, 0x01 and line_index[7:0] in turn, each advancing on transfer, with L_IDX advancing to PAYLOAD.
REQ-022 L_SYNC SHALL present its byte only when the FIFO is non-empty.
REQ-023 PAYLOAD SHALL pop one FIFO byte per transfer and keep valid_out=0 while the FIFO is empty.
REQ-024 PAYLOAD SHALL count exactly LINE_PIXELS transfers.
REQ-025 After the last payload byte of a line other than the last line, the block SHALL increment line_index and return to L_SYNC.
REQ-026 After the last payload byte of line LINES-1, the block SHALL increment frame_count (wrapping 255->0), clear line_index, and go to IDLE.
REQ-027 Output SHALL be registered: in PAYLOAD with the FIFO empty and ready_in=1, a byte sampled at edge k SHALL appear on data_out after edge k+1.
REQ-028 Header bytes SHALL appear one per cycle while ready_in=1, with no bubbles between header bytes.
REQ-029 Sustained throughput with ready_in=1 SHALL be one byte per cycle.
REQ-030 Payload bytes SHALL never equal 0xFF, so that 0xFF uniquely marks a sync.
REQ-031 Payload order SHALL equal input order, with no duplication.

Reset
REQ-032 On reset_n=0, the block SHALL immediately force the following, independent of the clock: state=IDLE, FIFO empty, valid_out=0, data_out=0x00, overflow=0, frame_count=0, line_index=0, pixel count=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet; the first byte after release SHALL be 0xFF (F_SYNC) once input arrives.
REQ-034 The overflow flag SHALL clear only on reset.

Verification (bench parameters LINE_PIXELS=4, LINES=2)
REQ-035 Stream 8 bytes 0x10..0x17 on consecutive cycles with ready_in=1 -> output FF 00 00 FF 01 00 10 11 12 13 FF 01 01 14 15 16 17, then frame_count=1.
REQ-036 Input byte 0xFF -> payload byte 0xFE.
REQ-037 Hold ready_in=0 for 20 cycles while streaming 20 bytes -> overflow=1 after the 17th byte, data_out stable throughout, exactly 16 payload bytes queued.
REQ-038 FIFO full with ready_in=1 in PAYLOAD, plus a push in the same cycle -> no drop, overflow stays 0.
REQ-039 Assert reset_n=0 asynchronously mid-payload -> outputs go to reset values before the next edge; the next frame starts FF 00 00.
REQ-040 Run 256 frames -> frame_count wraps to 0, and the F_CNT byte of frame 257 is 0x00.
